alu_seq_param: RTL and testbench

//   Parametrised, registered unsigned ALU: next generation of the 3-bit add/sub ALU.

---
 rtl/alu_seq_param.sv | 144 ++++++++++++++
 tb/tb_alu_seq_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Registered unsigned ALU with single-cycle add/sub and sequential multiply/divide.
// A start/busy/done handshake brackets each operation; operands are latched for display.
module alu_seq_param #(
   parameter int WIDTH = 3
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic [WIDTH-1:0]     x_q,
   output logic [WIDTH-1:0]     y_q,
   output logic [1:0]           op_q,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 uflow,
   output logic                 dbz
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      x_d, y_d;
   logic [1:0]            op_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0]    acc_q, acc_d;
   logic [2*WIDTH-1:0]    result_q, result_d;
   logic                  uflow_q, uflow_d;
   logic                  dbz_q, dbz_d;

   logic [WIDTH:0]        mul_sum;
   logic [2*WIDTH-1:0]    mul_next;
   logic [2*WIDTH:0]      div_sh;
   logic [WIDTH:0]        div_trial;
   logic [2*WIDTH-1:0]    div_next;

   // acc holds {high product, remaining multiplier} for mul and {remainder, dividend/quotient} for div
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, x_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      div_sh    = {acc_q, 1'b0};
      div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, y_q};
      if (div_sh[2*WIDTH:WIDTH] >= {1'b0, y_q})
         div_next = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
      else
         div_next = {div_sh[2*WIDTH-1:WIDTH], div_sh[WIDTH-1:1], 1'b0};
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      uflow_d  = uflow_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
               x_d     = x;
               y_d     = y;
               op_d    = op;
               uflow_d = 1'b0;
               dbz_d   = 1'b0;
               cnt_d   = (op[1] && !(op[0] && y == '0)) ? CW'(WIDTH - 1) : '0;
               acc_d   = (op == 2'b10) ? {{WIDTH{1'b0}}, y} : {{WIDTH{1'b0}}, x};
            end
         end
         CALC: begin
            case (op_q)
               2'b10:   acc_d = mul_next;
               2'b11:   acc_d = div_next;
               default: acc_d = acc_q;
            endcase
            if (cnt_q == '0) begin
               state_d = DONE;
               case (op_q)
                  2'b00: result_d = {{WIDTH{1'b0}}, x_q} + {{WIDTH{1'b0}}, y_q};
                  2'b01: begin
                     // Underflow saturates to zero rather than wrapping.
                     if (x_q >= y_q) begin
                        result_d = {{WIDTH{1'b0}}, x_q - y_q};
                     end else begin
                        result_d = '0;
                        uflow_d  = 1'b1;
                     end
                  end
                  2'b10: result_d = mul_next;
                  default: begin
                     if (y_q == '0) begin
                        result_d = {x_q, {WIDTH{1'b1}}};
                        dbz_d    = 1'b1;
                     end else begin
                        result_d = div_next;
                     end
                  end
               endcase
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         uflow_q  <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         uflow_q  <= uflow_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy   = (state_q == CALC);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign uflow  = uflow_q;
   assign dbz    = dbz_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: directed and random operations on WIDTH=3 and WIDTH=8 instances,
// compared against an arithmetic reference model.
module tb_alu_seq_param;

   localparam int W = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstn, start;
   logic [1:0]       op;
   logic [W-1:0]     x, y, x_q, y_q;
   logic [1:0]       op_q;
   logic             busy, done, uflow, dbz;
   logic [2*W-1:0]   result;

   logic             s8;
   logic [1:0]       op8, op8_q;
   logic [7:0]       x8, y8, x8_q, y8_q;
   logic             busy8, done8, uflow8, dbz8;
   logic [15:0]      result8;

   int total  = 0;
   int passed = 0;

   alu_seq_param #(.WIDTH(W)) u3 (
      .Clock(clk), .Resetn(rstn), .start(start), .op(op), .x(x), .y(y),
      .x_q(x_q), .y_q(y_q), .op_q(op_q), .busy(busy), .done(done),
      .result(result), .uflow(uflow), .dbz(dbz)
   );

   alu_seq_param #(.WIDTH(8)) u8 (
      .Clock(clk), .Resetn(rstn), .start(s8), .op(op8), .x(x8), .y(y8),
      .x_q(x8_q), .y_q(y8_q), .op_q(op8_q), .busy(busy8), .done(done8),
      .result(result8), .uflow(uflow8), .dbz(dbz8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [63:0] ref_res(input int w, input logic [1:0] o,
                                           input logic [63:0] a, input logic [63:0] b);
      case (o)
         2'd0:    return a + b;
         2'd1:    return (a >= b) ? a - b : 64'd0;
         2'd2:    return a * b;
         default: return (b == 0) ? ((a << w) | ((64'd1 << w) - 1))
                                  : (((a % b) << w) | (a / b));
      endcase
   endfunction

   function automatic int ref_lat(input int w, input logic [1:0] o, input logic [63:0] b);
      return (o == 2'd2 || (o == 2'd3 && b != 0)) ? w : 1;
   endfunction

   task automatic run3(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke, input string tag);
      int n, nb;
      @(negedge clk);
      start = 1'b1; op = o; x = a; y = b;
      @(posedge clk); #1;
      chk({tag, " busy_e0"}, busy, 1);
      nb = 1;
      if (poke) begin
         start = 1'b1; op = 2'b00;
      end else begin
         start = 1'b0; op = 2'($urandom);
      end
      x = W'($urandom); y = W'($urandom);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (busy === 1'b1) nb++;
      end
      start = 1'b0;
      chk({tag, " latency"}, n, ref_lat(W, o, b));
      chk({tag, " busy_cycles"}, nb, ref_lat(W, o, b));
      chk({tag, " result"}, result, ref_res(W, o, a, b));
      chk({tag, " uflow"}, uflow, (o == 2'd1 && a < b));
      chk({tag, " dbz"}, dbz, (o == 2'd3 && b == 0));
      chk({tag, " x_q"}, x_q, a);
      chk({tag, " y_q"}, y_q, b);
      chk({tag, " op_q"}, op_q, o);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " result_held"}, result, ref_res(W, o, a, b));
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input string tag);
      int n;
      @(negedge clk);
      s8 = 1'b1; op8 = o; x8 = a; y8 = b;
      @(posedge clk); #1;
      s8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, n, ref_lat(8, o, b));
      chk({tag, " result"}, result8, ref_res(8, o, a, b));
      chk({tag, " uflow"}, uflow8, (o == 2'd1 && a < b));
      chk({tag, " dbz"}, dbz8, (o == 2'd3 && b == 0));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rstn = 1'b0; start = 1'b0; op = '0; x = '0; y = '0;
      s8 = 1'b0; op8 = '0; x8 = '0; y8 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst result", result, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst uflow", uflow, 0);
      chk("rst dbz", dbz, 0);
      chk("rst xyop", {x_q, y_q, op_q}, 0);
      chk("rst result8", result8, 0);
      @(negedge clk);
      rstn = 1'b1;

      run3(2'd0, 3'd7, 3'd7, 1'b0, "add_7_7");
      run3(2'd1, 3'd3, 3'd4, 1'b0, "sub_uflow");
      run3(2'd1, 3'd6, 3'd2, 1'b0, "sub_6_2");
      run3(2'd2, 3'd7, 3'd6, 1'b0, "mul_7_6");
      run3(2'd3, 3'd7, 3'd2, 1'b0, "div_7_2");
      run3(2'd3, 3'd5, 3'd0, 1'b0, "div_by_0");
      run3(2'd2, 3'd7, 3'd6, 1'b1, "mul_start_busy");
      run3(2'd1, 3'd4, 3'd4, 1'b0, "sub_equal");
      run3(2'd3, 3'd0, 3'd7, 1'b0, "div_0_7");
      run3(2'd3, 3'd7, 3'd7, 1'b0, "div_7_7");
      run3(2'd3, 3'd7, 3'd1, 1'b0, "div_7_1");
      run3(2'd2, 3'd0, 3'd5, 1'b0, "mul_0_5");

      // Abort a multiply part-way through with reset.
      @(negedge clk);
      start = 1'b1; op = 2'd2; x = 3'd5; y = 3'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("midrst result", result, 0);
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst xyop", {x_q, y_q, op_q, uflow, dbz}, 0);
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("midrst no_done", seen, 0);
      run3(2'd2, 3'd5, 3'd3, 1'b0, "after_rst");

      for (int i = 0; i < 40; i++)
         run3(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), "rand3");

      run8(2'd2, 8'd255, 8'd255, "mul8_max");
      run8(2'd3, 8'd255, 8'd16, "div8");
      run8(2'd3, 8'd200, 8'd0, "div8_by_0");
      run8(2'd1, 8'd0, 8'd1, "sub8_uflow");
      run8(2'd0, 8'd255, 8'd255, "add8_max");
      for (int i = 0; i < 12; i++)
         run8(2'($urandom), 8'($urandom), 8'($urandom), "rand8");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
